// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - ready/valid byte channel carrying received UART data
interface uart_rx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with one-entry holding register
module uart_rx #(
    parameter int FREQUENCY = 50000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       io_rxd,
    uart_rx_if.master  io_channel,
    output logic       io_frame_err,
    output logic       io_overrun
);
    localparam int BIT_CNT  = (FREQUENCY + BAUD_RATE / 2) / BAUD_RATE - 1;
    localparam int HALF_CNT = BIT_CNT / 2;
    localparam int CNT_W    = (BIT_CNT < 1) ? 1 : $clog2(BIT_CNT + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t           state;
    logic [1:0]       sync_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [3:0]       bits_reg;
    logic [7:0]       shift_reg;
    logic [7:0]       data_reg;
    logic             valid_reg;
    logic             rx;

    assign rx               = sync_reg[1];
    assign io_channel.data  = data_reg;
    assign io_channel.valid = valid_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            sync_reg     <= 2'b11;
            cnt_reg      <= '0;
            bits_reg     <= '0;
            shift_reg    <= '0;
            data_reg     <= '0;
            valid_reg    <= 1'b0;
            io_frame_err <= 1'b0;
            io_overrun   <= 1'b0;
        end else begin
            sync_reg     <= {sync_reg[0], io_rxd};
            io_frame_err <= 1'b0;
            io_overrun   <= 1'b0;

            // A consume clears valid unless a delivery below reloads it this cycle.
            if (valid_reg && io_channel.ready)
                valid_reg <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx) begin
                        cnt_reg <= CNT_W'(HALF_CNT);
                        state   <= START;
                    end
                end
                START: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else if (!rx) begin
                        cnt_reg  <= CNT_W'(BIT_CNT);
                        bits_reg <= 4'd8;
                        state    <= DATA;
                    end else begin
                        state <= IDLE;
                    end
                end
                DATA: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else begin
                        shift_reg <= {rx, shift_reg[7:1]};
                        bits_reg  <= bits_reg - 1'b1;
                        cnt_reg   <= CNT_W'(BIT_CNT);
                        if (bits_reg == 4'd1)
                            state <= STOP;
                    end
                end
                STOP: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else if (rx) begin
                        if (!valid_reg || io_channel.ready) begin
                            data_reg  <= shift_reg;
                            valid_reg <= 1'b1;
                        end else begin
                            io_overrun <= 1'b1;
                        end
                        state <= IDLE;
                    end else begin
                        io_frame_err <= 1'b1;
                        state        <= WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    // A held-low break reports once, then waits for the line to recover.
                    if (rx)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at a 10-cycle bit period
module tb_uart_rx;
    logic clk = 1'b0;
    logic reset;
    logic rxd;
    logic frame_err;
    logic overrun;

    uart_rx_if ch ();

    uart_rx #(.FREQUENCY(10), .BAUD_RATE(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .io_rxd       (rxd),
        .io_channel   (ch),
        .io_frame_err (frame_err),
        .io_overrun   (overrun)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         err_cnt = 0;
    int         ovr_cnt = 0;
    logic [7:0] exp_q[$];
    logic       presented = 1'b0;
    logic       prev_err = 1'b0;
    logic       prev_ovr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares each newly presented byte against the scoreboard and counts pulses.
    always @(negedge clk) begin
        if (reset) begin
            presented = 1'b0;
        end else begin
            if (ch.valid && !presented) begin
                presented = 1'b1;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_valid: got data %0h with nothing expected", ch.data);
                end else begin
                    check("rx_data", {24'd0, ch.data}, {24'd0, exp_q.pop_front()});
                end
            end
            if (ch.valid && ch.ready)
                presented = 1'b0;
            if (frame_err) begin
                if (prev_err) check("frame_err_width", 32'd2, 32'd1);
                else err_cnt++;
            end
            if (overrun) begin
                if (prev_ovr) check("overrun_width", 32'd2, 32'd1);
                else ovr_cnt++;
            end
        end
        prev_err = frame_err;
        prev_ovr = overrun;
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit ready_pulse,
                              input int abort_bit);
        rxd = 1'b0;
        for (int k = 0; k < 8; k++) begin
            repeat (10) @(posedge clk); #1;
            rxd = b[k];
            if (abort_bit == k) begin
                repeat (5) @(posedge clk); #1;
                reset = 1'b1;
                rxd   = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                return;
            end
        end
        repeat (10) @(posedge clk); #1;
        rxd = stop;
        if (ready_pulse) begin
            repeat (7) @(posedge clk); #1;
            ch.ready = 1'b1;
            @(posedge clk); #1;
            ch.ready = 1'b0;
            repeat (2) @(posedge clk); #1;
        end else begin
            repeat (10) @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk); #1;
    endtask

    task automatic pulse_ready();
        ch.ready = 1'b1;
        @(posedge clk); #1;
        ch.ready = 1'b0;
    endtask

    task automatic end_test(input string name, input int exp_err, input int exp_ovr);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check({name, "_pending"}, exp_q.size(), 0);
        check({name, "_frame_errs"}, err_cnt, exp_err);
        check({name, "_overruns"}, ovr_cnt, exp_ovr);
        err_cnt = 0;
        ovr_cnt = 0;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        rxd      = 1'b1;
        ch.ready = 1'b0;
        idle(3);
        check("reset_valid", ch.valid, 0);
        check("reset_data", ch.data, 8'h00);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        reset = 1'b0;
        idle(5);

        // Single byte held until consumed
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1'b0, -1);
        idle(20);
        check("single_valid_held", ch.valid, 1);
        check("single_data_held", ch.data, 8'h55);
        pulse_ready();
        check("single_valid_cleared", ch.valid, 0);
        end_test("single", 0, 0);

        // Back-to-back frames with ready high
        ch.ready = 1'b1;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        idle(5);
        check("b2b_valid_after", ch.valid, 0);
        ch.ready = 1'b0;
        end_test("b2b", 0, 0);

        // Framing error followed by a break, then a clean frame
        send_frame(8'h81, 1'b0, 1'b0, -1);
        idle(30);
        check("ferr_no_valid", ch.valid, 0);
        rxd = 1'b1;
        idle(20);
        check("ferr_single_pulse", err_cnt, 1);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, 1'b0, -1);
        idle(3);
        pulse_ready();
        end_test("ferr", 1, 0);

        // Overrun: second byte dropped
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0, -1);
        send_frame(8'h22, 1'b1, 1'b0, -1);
        idle(3);
        check("ovr_valid_kept", ch.valid, 1);
        check("ovr_data_kept", ch.data, 8'h11);
        pulse_ready();
        check("ovr_drained", ch.valid, 0);
        end_test("ovr", 0, 1);

        // Consume in the delivery cycle is not an overrun
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b1, 1'b0, -1);
        send_frame(8'h22, 1'b1, 1'b1, -1);
        idle(3);
        check("simul_valid", ch.valid, 1);
        check("simul_data", ch.data, 8'h22);
        pulse_ready();
        end_test("simul", 0, 0);

        // Glitch rejection, then a frame proves the receiver is idle again
        rxd = 1'b0;
        idle(2);
        rxd = 1'b1;
        idle(20);
        check("glitch_no_valid", ch.valid, 0);
        check("glitch_no_pulses", err_cnt + ovr_cnt, 0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0, -1);
        idle(3);
        pulse_ready();
        end_test("glitch", 0, 0);

        // Reset during bit 3 of 0xF0
        send_frame(8'hF0, 1'b1, 1'b0, 3);
        check("rst_valid", ch.valid, 0);
        idle(20);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1, 1'b0, -1);
        idle(3);
        pulse_ready();
        idle(5);
        end_test("rst", 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
